// File: rtl/sum_packer_if.sv
// Byte-stream input and word valid/ready output bundle for sum_packer.
interface sum_packer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          i_valid;
  logic [7:0]                    i_data;
  logic                          i_flush;
  logic                          o_valid;
  logic [31:0]                   o_data;
  logic [2:0]                    o_bytes;
  logic                          i_ready;
  logic [$clog2(FIFO_DEPTH):0]   o_level;
  logic [15:0]                   o_drop_cnt;

  modport slave (
    input  i_valid, i_data, i_flush, i_ready,
    output o_valid, o_data, o_bytes, o_level, o_drop_cnt
  );

  modport master (
    output i_valid, i_data, i_flush, i_ready,
    input  o_valid, o_data, o_bytes, o_level, o_drop_cnt
  );
endinterface

// File: rtl/sum_packer.sv
// Packs adder bytes into little-endian 32-bit words, buffers them in a
// first-word-fall-through FIFO and drops/counts words that arrive when full.
module sum_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_x,
  sum_packer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [1:0]             lane_q, lane_d;
  logic [2:0][7:0]        partial_q, partial_d;
  logic [31:0]            data_mem_q [FIFO_DEPTH];
  logic [31:0]            data_mem_d [FIFO_DEPTH];
  logic [2:0]             bytes_mem_q [FIFO_DEPTH];
  logic [2:0]             bytes_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  logic [3:0][7:0]        word_c;
  logic [2:0]             commit_bytes;
  logic                   commit;
  logic                   pop;
  logic                   full;
  logic                   push;

  always_comb begin
    // Lanes above the current one are always zero in the partial register,
    // so the committed word needs no extra masking.
    word_c = {8'h00, partial_q};
    if (bus.i_valid) word_c[lane_q] = bus.i_data;

    commit       = (bus.i_valid && (lane_q == 2'd3 || bus.i_flush)) ||
                   (bus.i_flush && !bus.i_valid && lane_q != 2'd0);
    commit_bytes = {1'b0, lane_q} + {2'b00, bus.i_valid};
    pop          = (level_q != '0) && bus.i_ready;
    full         = (level_q == LVL_W'(FIFO_DEPTH));
    push         = commit && (!full || pop);

    lane_d      = lane_q;
    partial_d   = partial_q;
    data_mem_d  = data_mem_q;
    bytes_mem_d = bytes_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    drop_cnt_d  = drop_cnt_q;

    if (commit) begin
      lane_d    = 2'd0;
      partial_d = '0;
    end else if (bus.i_valid) begin
      lane_d    = lane_q + 2'd1;
      partial_d = word_c[2:0];
    end

    if (push) begin
      data_mem_d[wr_ptr_q]  = word_c;
      bytes_mem_d[wr_ptr_q] = commit_bytes;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (commit && !push && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      lane_q      <= '0;
      partial_q   <= '0;
      data_mem_q  <= '{default: '0};
      bytes_mem_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      lane_q      <= lane_d;
      partial_q   <= partial_d;
      data_mem_q  <= data_mem_d;
      bytes_mem_q <= bytes_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.o_valid    = (level_q != '0);
  assign bus.o_data     = (level_q != '0) ? data_mem_q[rd_ptr_q]  : '0;
  assign bus.o_bytes    = (level_q != '0) ? bytes_mem_q[rd_ptr_q] : '0;
  assign bus.o_level    = level_q;
  assign bus.o_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_sum_packer.sv
// Directed self-checking bench for sum_packer with hand-computed expectations.
module tb_sum_packer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_x;
  int   n_checks;
  int   n_fail;

  sum_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  sum_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_x (rst_x),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic flush);
    bus.i_valid = 1'b1;
    bus.i_data  = b;
    bus.i_flush = flush;
    tick();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_x       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    tick();
    tick();
    rst_x = 1'b0;
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_data",  bus.o_data, 32'd0);
    check("rst_bytes", 32'(bus.o_bytes), 32'd0);
    check("rst_level", 32'(bus.o_level), 32'd0);
    check("rst_drop",  32'(bus.o_drop_cnt), 32'd0);

    // Four consecutive bytes, output one cycle after the 4th.
    bus.i_ready = 1'b1;
    send(8'h11, 1'b0);
    check("lat_not_early", 32'(bus.o_valid), 32'd0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("w4_valid", 32'(bus.o_valid), 32'd1);
    check("w4_data",  bus.o_data, 32'h44332211);
    check("w4_bytes", 32'(bus.o_bytes), 32'd4);
    check("w4_level", 32'(bus.o_level), 32'd1);
    tick();
    check("w4_popped", 32'(bus.o_level), 32'd0);
    check("w4_empty_data", bus.o_data, 32'd0);

    // Flush of a partial word, then flush together with a byte at lane 0.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    check("partial_no_out", 32'(bus.o_valid), 32'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("fl2_data",  bus.o_data, 32'h0000BBAA);
    check("fl2_bytes", 32'(bus.o_bytes), 32'd2);
    send(8'hCC, 1'b1);
    check("fl1_data",  bus.o_data, 32'h000000CC);
    check("fl1_bytes", 32'(bus.o_bytes), 32'd1);
    check("fl1_level", 32'(bus.o_level), 32'd1);
    tick();
    check("fl_drained", 32'(bus.o_level), 32'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("flush_lane0_noop", 32'(bus.o_level), 32'd0);

    // Overflow: 6 words into a 4-deep FIFO with the consumer stalled.
    bus.i_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(8'(i), 1'b0);
    check("ovf_level", 32'(bus.o_level), 32'd4);
    check("ovf_drop",  32'(bus.o_drop_cnt), 32'd2);
    tick();
    check("ovf_hold_data", bus.o_data, 32'h03020100);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_data",  bus.o_data, 32'h03020100 + 32'(k) * 32'h04040404);
      check("drain_bytes", 32'(bus.o_bytes), 32'd4);
      tick();
    end
    check("drain_empty", 32'(bus.o_valid), 32'd0);

    // Full FIFO with a 4th byte and a pop on the same edge.
    bus.i_ready = 1'b0;
    for (int i = 0; i < 19; i++) send(8'h20 + 8'(i), 1'b0);
    check("full_level", 32'(bus.o_level), 32'd4);
    bus.i_ready = 1'b1;
    send(8'h33, 1'b0);
    bus.i_ready = 1'b0;
    check("pushpop_level", 32'(bus.o_level), 32'd4);
    check("pushpop_drop",  32'(bus.o_drop_cnt), 32'd2);
    check("pushpop_head",  bus.o_data, 32'h27262524);

    // Reset mid-word with words queued; byte in the reset cycle is ignored.
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    rst_x       = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hEE;
    tick();
    rst_x       = 1'b0;
    bus.i_valid = 1'b0;
    check("mrst_valid", 32'(bus.o_valid), 32'd0);
    check("mrst_data",  bus.o_data, 32'd0);
    check("mrst_bytes", 32'(bus.o_bytes), 32'd0);
    check("mrst_level", 32'(bus.o_level), 32'd0);
    check("mrst_drop",  32'(bus.o_drop_cnt), 32'd0);
    bus.i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    check("post_rst_data",  bus.o_data, 32'h04030201);
    check("post_rst_bytes", 32'(bus.o_bytes), 32'd4);
    tick();

    // Saturate the drop counter with one-byte words every cycle.
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_data  = 8'h5A;
    for (int i = 0; i < 4 + 65534; i++) tick();
    check("sat_pre", 32'(bus.o_drop_cnt), 32'h0000FFFE);
    tick();
    check("sat_hit", 32'(bus.o_drop_cnt), 32'h0000FFFF);
    for (int i = 0; i < 5; i++) tick();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    check("sat_hold",  32'(bus.o_drop_cnt), 32'h0000FFFF);
    check("sat_level", 32'(bus.o_level), 32'd4);
    check("sat_head",  bus.o_data, 32'h0000005A);
    check("sat_bytes", 32'(bus.o_bytes), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
